// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and helpers for the sync_fifo write arbiter.
// Holds the FSM state type, the requester bound and a one-hot encoder.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package sync_fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    localparam int ARB_MAX_REQ = 16;
    localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

    // OR-reduction encoder; the input is expected to be one-hot or zero.
    function automatic logic [ARB_IDX_W-1:0] onehot2idx(
        input logic [ARB_MAX_REQ-1:0] oh
    );
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo_rr_pick.sv
// Rotating-priority picker: first set req bit after ptr, wrapping.
// Ports: req (requests), ptr (last winner), winner (index), any (|req).
module sync_fifo_rr_pick
    import sync_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan ptr+1 .. ptr+NUM_REQ; ptr itself is checked last.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one sync_fifo write port.
// Ports: i_clk, i_rst_n; per-requester i_req_valid/i_req_data/o_req_ready;
// FIFO side o_fifo_valid/o_fifo_data/i_fifo_ready/i_fifo_almostfull;
// status o_grant (one-hot owner) and o_busy (burst in progress).
module sync_fifo_wr_arb
    import sync_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_valid,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    input  logic                          i_fifo_ready,
    input  logic                          i_fifo_almostfull,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  busy;
    logic                  own_valid;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] data_mux;

    sync_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (i_req_valid),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

    assign busy      = (state_q == ARB_BURST);
    assign own_valid = |(grant_q & i_req_valid);
    assign last_beat = (cnt_q == CNT_WIDTH'(MAX_BURST - 1));

    // grant_q is one-hot in BURST, so an AND-OR mux selects the owner.
    always_comb begin
        data_mux = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                data_mux = data_mux
                         | i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any && !i_fifo_almostfull) begin
                    state_d           = ARB_BURST;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    ptr_d             = pick_idx;
                    cnt_d             = '0;
                end
            end
            ARB_BURST: begin
                // Owner dropping valid ends the burst even while stalled.
                if (!own_valid) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (i_fifo_ready) begin
                    if (last_beat) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy       = busy;
    assign o_grant      = grant_q;
    assign o_fifo_valid = busy && own_valid;
    assign o_fifo_data  = busy ? data_mux : '0;
    assign o_req_ready  = busy ? (grant_q & {NUM_REQ{i_fifo_ready}})
                               : '0;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb with a queue-based FIFO sink and
// a transaction-level arbitration model.
module tb_sync_fifo_wr_arb;

    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int MB     = 4;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 2;

    logic            i_clk;
    logic            i_rst_n;
    logic [NR-1:0]   i_req_valid;
    logic [NR*DW-1:0] i_req_data;
    logic [NR-1:0]   o_req_ready;
    logic            o_fifo_valid;
    logic [DW-1:0]   o_fifo_data;
    logic            i_fifo_ready;
    logic            i_fifo_almostfull;
    logic [NR-1:0]   o_grant;
    logic            o_busy;

    sync_fifo_wr_arb #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_req_valid       (i_req_valid),
        .i_req_data        (i_req_data),
        .o_req_ready       (o_req_ready),
        .o_fifo_valid      (o_fifo_valid),
        .o_fifo_data       (o_fifo_data),
        .i_fifo_ready      (i_fifo_ready),
        .i_fifo_almostfull (i_fifo_almostfull),
        .o_grant           (o_grant),
        .o_busy            (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus state
    logic [7:0] rq [NR][$];
    logic [NR-1:0] en;
    logic force_stall, force_af, drain_en;

    // FIFO sink and scoreboard
    logic [7:0] fq [$];
    logic [7:0] exp_q [$];

    // model: owner (-1 idle), last winner, beats in current burst
    int m_own, m_last, m_beats;

    // observation logs
    int grants [$];
    int beats [$];
    int gaps [$];
    int obs_data [$];
    bit prev_busy, seen;
    int idle_run;

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic m_reset();
        m_own   = -1;
        m_last  = NR - 1;
        m_beats = 0;
    endtask

    task automatic clear_logs();
        grants.delete();
        beats.delete();
        gaps.delete();
        obs_data.delete();
        prev_busy = 1'b0;
        seen      = 1'b0;
        idle_run  = 0;
    endtask

    task automatic step();
        logic [NR-1:0] v;
        logic [NR*DW-1:0] d;
        logic rdy, af, s_push;
        logic [7:0] s_data, pd;
        logic [NR-1:0] eg, er;
        logic ev;
        logic [7:0] ed;
        v = '0;
        d = {NR{8'hee}};
        for (int k = 0; k < NR; k++) begin
            if (en[k] && rq[k].size() > 0) begin
                v[k] = 1'b1;
                d[k*DW +: DW] = rq[k][0];
            end
        end
        rdy = (fq.size() < DEPTH) && !force_stall;
        af  = (fq.size() >= DEPTH - AF_LVL) || force_af;
        i_req_valid       = v;
        i_req_data        = d;
        i_fifo_ready      = rdy;
        i_fifo_almostfull = af;
        @(negedge i_clk);
        eg = '0; er = '0; ev = 1'b0; ed = '0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ev = v[m_own];
            ed = d[m_own*DW +: DW];
            er = rdy ? eg : '0;
        end
        chk("grant", o_grant, eg);
        chk("busy", o_busy, m_own >= 0);
        chk("fifo_valid", o_fifo_valid, ev);
        chk("fifo_data", o_fifo_data, ed);
        chk("req_ready", o_req_ready, er);
        chk("inv_valid_busy", !o_fifo_valid || o_busy, 1);
        s_push = o_fifo_valid && i_fifo_ready && i_rst_n;
        s_data = o_fifo_data;
        if (i_rst_n) begin
            if (o_busy && !prev_busy) begin
                if (seen) gaps.push_back(idle_run);
                grants.push_back(int'(o_grant));
                beats.push_back(0);
                seen = 1'b1;
                idle_run = 0;
            end else if (!o_busy) begin
                idle_run++;
            end
            prev_busy = o_busy;
        end
        @(posedge i_clk);
        if (i_rst_n) begin
            if (drain_en && fq.size() > 0) begin
                pd = fq.pop_front();
                if (exp_q.size() > 0) chk("fifo_rd", pd, exp_q.pop_front());
                else chk("fifo_extra_rd", pd, 32'hffff_ffff);
            end
            if (s_push) begin
                fq.push_back(s_data);
                obs_data.push_back(int'(s_data));
                if (beats.size() > 0) beats[beats.size()-1] += 1;
            end
            if (m_own < 0) begin
                if (v != '0 && !af) begin
                    for (int i = 1; i <= NR; i++) begin
                        if (v[(m_last + i) % NR]) begin
                            m_own = (m_last + i) % NR;
                            break;
                        end
                    end
                    m_last  = m_own;
                    m_beats = 0;
                end
            end else if (!v[m_own]) begin
                m_own = -1;
            end else if (rdy) begin
                exp_q.push_back(rq[m_own].pop_front());
                m_beats++;
                if (m_beats == MB) m_own = -1;
            end
        end
        #1;
    endtask

    task automatic quiesce();
        en = '0;
        force_stall = 1'b0;
        force_af = 1'b0;
        for (int k = 0; k < NR; k++) rq[k].delete();
        repeat (3) step();
    endtask

    task automatic wait_beats(input int own, input int n, input string tag);
        int t;
        t = 0;
        while (!(m_own == own && m_beats == n) && t < 30) begin
            step();
            t++;
        end
        chk(tag, t < 30, 1);
    endtask

    int exp_g [5] = '{1, 2, 4, 8, 1};
    int nd;

    initial begin
        i_rst_n = 1'b0;
        i_req_valid = '0;
        i_req_data = '0;
        i_fifo_ready = 1'b0;
        i_fifo_almostfull = 1'b0;
        en = '0;
        force_stall = 1'b0;
        force_af = 1'b0;
        drain_en = 1'b1;
        m_reset();
        clear_logs();

        // reset with every requester valid
        for (int k = 0; k < NR; k++)
            for (int i = 0; i < 8; i++) rq[k].push_back(8'((k << 4) | i));
        en = 4'hf;
        repeat (3) step();
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_fvalid", o_fifo_valid, 0);
        chk("rst_ready", o_req_ready, 0);
        i_rst_n = 1'b1;
        clear_logs();
        step();
        chk("first_grant", o_grant, 4'b0001);

        // all four requesting: full rotation, 4 beats each
        repeat (25) step();
        for (int i = 0; i < 5; i++) chk("rot_grant", qat(grants, i), exp_g[i]);
        for (int i = 0; i < 4; i++) chk("rot_beats", qat(beats, i), MB);
        for (int i = 0; i < 4; i++) chk("rot_gap", qat(gaps, i), 1);
        quiesce();

        // single requester streaming 0x10..0x17
        clear_logs();
        for (int i = 0; i < 8; i++) rq[1].push_back(8'(8'h10 + i));
        en = 4'b0010;
        repeat (14) step();
        chk("solo_nb", grants.size(), 2);
        chk("solo_g0", qat(grants, 0), 4'b0010);
        chk("solo_g1", qat(grants, 1), 4'b0010);
        chk("solo_b0", qat(beats, 0), MB);
        chk("solo_b1", qat(beats, 1), MB);
        chk("solo_gap", qat(gaps, 0), 1);
        for (int i = 0; i < 8; i++) chk("solo_data", qat(obs_data, i), 8'h10 + i);
        quiesce();

        // stall after beat 2
        clear_logs();
        for (int i = 0; i < 4; i++) rq[1].push_back(8'(8'h20 + i));
        en = 4'b0010;
        wait_beats(1, 2, "stall_reach");
        force_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", o_fifo_valid, 1);
            chk("stall_data", o_fifo_data, 8'h22);
            chk("stall_grant", o_grant, 4'b0010);
        end
        force_stall = 1'b0;
        repeat (8) step();
        chk("stall_beats", qat(beats, 0), MB);
        for (int i = 0; i < 4; i++) chk("stall_seq", qat(obs_data, i), 8'h20 + i);
        quiesce();

        // almostfull gates grants only in IDLE
        clear_logs();
        for (int i = 0; i < 6; i++) rq[2].push_back(8'(8'h30 + i));
        en = 4'b0100;
        force_af = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("af_hold", o_grant, 0);
        end
        force_af = 1'b0;
        step();
        chk("af_grant", o_grant, 4'b0100);
        step();
        force_af = 1'b1;
        repeat (8) step();
        chk("af_beats", qat(beats, 0), MB);
        chk("af_nb", grants.size(), 1);
        quiesce();

        // owner drops valid, then reset mid-burst
        i_rst_n = 1'b0;
        m_reset();
        repeat (2) step();
        i_rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 6; i++) rq[0].push_back(8'(8'h40 + i));
        for (int i = 0; i < 8; i++) rq[3].push_back(8'(8'h50 + i));
        en = 4'b1001;
        wait_beats(0, 2, "drop_reach");
        en[0] = 1'b0;
        repeat (4) step();
        chk("drop_g0", qat(grants, 0), 4'b0001);
        chk("drop_b0", qat(beats, 0), 2);
        chk("drop_gap", qat(gaps, 0), 1);
        chk("drop_g1", qat(grants, 1), 4'b1000);
        chk("mid_busy", o_busy, 1);
        nd = obs_data.size();
        i_rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_grant", o_grant, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_fvalid", o_fifo_valid, 0);
        chk("arst_fdata", o_fifo_data, 0);
        chk("arst_ready", o_req_ready, 0);
        repeat (2) step();
        chk("arst_nobeat", obs_data.size(), nd);
        i_rst_n = 1'b1;
        clear_logs();
        en = 4'b1001;
        repeat (3) step();
        chk("arst_prio", qat(grants, 0), 4'b0001);
        quiesce();

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (rq[k].size() < 3 && $urandom_range(3) == 0)
                    rq[k].push_back(8'($urandom));
                en[k] = ($urandom_range(9) != 0);
            end
            drain_en    = $urandom_range(1);
            force_af    = ($urandom_range(15) == 0);
            force_stall = ($urandom_range(7) == 0);
            step();
        end

        drain_en = 1'b1;
        quiesce();
        for (int t = 0; t < 100 && fq.size() > 0; t++) step();
        chk("end_fifo_empty", fq.size(), 0);
        chk("end_lost", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
